fifo_enq_arbiter: RTL and testbench

FIFO_ENQ_ARBITER -- requirements
Module: fifo_enq_arbiter

---
 rtl/fifo_enq_arbiter.sv | 149 ++++++++++++++
 tb/tb_fifo_enq_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_enq_arbiter.sv
// Round-robin arbiter that merges NREQ valid/ready requesters into one FIFO enqueue port.
// A granted requester keeps the port for up to MAXBURST transfers; the data path is combinational.
module fifo_enq_arbiter #(
    parameter int WIDTH    = 8,
    parameter int NREQ     = 4,
    parameter int MAXBURST = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_val,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           req_rdy,
    output logic                      enq_val,
    output logic [WIDTH-1:0]          enq_data,
    output logic [$clog2(NREQ)-1:0]   enq_src,
    input  logic                      enq_rdy,
    output logic [15:0]               xfer_count
);

    localparam int SW = $clog2(NREQ);

    typedef enum logic {
        ST_IDLE,
        ST_LOCK
    } state_t;

    state_t          r_state,    w_state_nxt;
    logic [SW-1:0]   r_owner,    w_owner_nxt;
    logic [SW-1:0]   r_rr_ptr,   w_rr_ptr_nxt;
    logic [3:0]      r_burst,    w_burst_nxt;
    logic            r_pending,  w_pending_nxt;
    logic [SW-1:0]   r_pend_idx, w_pend_idx_nxt;
    logic [15:0]     r_xfer_count, w_xfer_count_nxt;

    logic [SW-1:0]   w_sel;
    logic            w_sel_hit;
    logic [SW-1:0]   w_cand;
    logic            w_enq_val;
    logic [WIDTH-1:0] w_data;
    logic            w_xfer;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_rr_ptr     <= '0;
            r_burst      <= '0;
            r_pending    <= 1'b0;
            r_pend_idx   <= '0;
            r_xfer_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_burst      <= w_burst_nxt;
            r_pending    <= w_pending_nxt;
            r_pend_idx   <= w_pend_idx_nxt;
            r_xfer_count <= w_xfer_count_nxt;
        end
    end

    // Selection and output drive. A refused IDLE offer stays pinned to its requester
    // until it transfers or withdraws, so enq_src never changes under backpressure.
    always_comb begin
        w_sel     = '0;
        w_sel_hit = 1'b0;
        w_cand    = '0;
        if (r_state == ST_LOCK) begin
            w_sel     = r_owner;
            w_sel_hit = 1'b1;
        end else if (r_pending && req_val[r_pend_idx]) begin
            w_sel     = r_pend_idx;
            w_sel_hit = 1'b1;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                w_cand = r_rr_ptr + SW'(i);
                if (!w_sel_hit && req_val[w_cand]) begin
                    w_sel     = w_cand;
                    w_sel_hit = 1'b1;
                end
            end
        end

        w_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_sel_hit && (w_sel == SW'(i))) begin
                w_data = req_data[i*WIDTH +: WIDTH];
            end
        end

        // Offer is suppressed while reset is high so nothing can transfer in that cycle.
        w_enq_val = w_sel_hit && req_val[w_sel] && !reset;
        w_xfer    = w_enq_val && enq_rdy;

        enq_val  = w_enq_val;
        enq_data = w_data;
        enq_src  = w_sel;
        req_rdy  = w_xfer ? (NREQ'(1) << w_sel) : '0;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_burst_nxt      = r_burst;
        w_pending_nxt    = r_pending;
        w_pend_idx_nxt   = r_pend_idx;
        w_xfer_count_nxt = w_xfer ? r_xfer_count + 16'd1 : r_xfer_count;

        unique case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_owner_nxt   = w_sel;
                    w_burst_nxt   = 4'd1;
                    w_pending_nxt = 1'b0;
                    if (MAXBURST == 1) begin
                        w_rr_ptr_nxt = w_sel + SW'(1);
                    end else begin
                        w_state_nxt = ST_LOCK;
                    end
                end else if (w_enq_val) begin
                    w_pending_nxt  = 1'b1;
                    w_pend_idx_nxt = w_sel;
                end else begin
                    w_pending_nxt = 1'b0;
                end
            end
            ST_LOCK: begin
                w_pending_nxt = 1'b0;
                if (!req_val[r_owner]) begin
                    w_state_nxt  = ST_IDLE;
                    w_rr_ptr_nxt = r_owner + SW'(1);
                end else if (w_xfer) begin
                    w_burst_nxt = r_burst + 4'd1;
                    if ((r_burst + 4'd1) == 4'(MAXBURST)) begin
                        w_state_nxt  = ST_IDLE;
                        w_rr_ptr_nxt = r_owner + SW'(1);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign xfer_count = r_xfer_count;

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Bench for fifo_enq_arbiter: directed scenarios, a round-robin vector table and
// randomized traffic checked against a queue-free behavioural model of the arbitration rules.
module tb_fifo_enq_arbiter;

    logic        clk;
    logic        reset;

    // Instance A: MAXBURST 4
    logic [3:0]  a_req_val;
    logic [31:0] a_req_data;
    logic [3:0]  a_req_rdy;
    logic        a_enq_val;
    logic [7:0]  a_enq_data;
    logic [1:0]  a_enq_src;
    logic        a_enq_rdy;
    logic [15:0] a_xfer_count;

    // Instance B: MAXBURST 2
    logic [3:0]  b_req_val;
    logic [31:0] b_req_data;
    logic [3:0]  b_req_rdy;
    logic        b_enq_val;
    logic [7:0]  b_enq_data;
    logic [1:0]  b_enq_src;
    logic        b_enq_rdy;
    logic [15:0] b_xfer_count;

    int n_checks = 0;
    int n_errors = 0;

    fifo_enq_arbiter #(.WIDTH(8), .NREQ(4), .MAXBURST(4)) u_dut_a (
        .clk(clk), .reset(reset),
        .req_val(a_req_val), .req_data(a_req_data), .req_rdy(a_req_rdy),
        .enq_val(a_enq_val), .enq_data(a_enq_data), .enq_src(a_enq_src),
        .enq_rdy(a_enq_rdy), .xfer_count(a_xfer_count)
    );

    fifo_enq_arbiter #(.WIDTH(8), .NREQ(4), .MAXBURST(2)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_val(b_req_val), .req_data(b_req_data), .req_rdy(b_req_rdy),
        .enq_val(b_enq_val), .enq_data(b_enq_data), .enq_src(b_enq_src),
        .enq_rdy(b_enq_rdy), .xfer_count(b_xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        a_req_val = '0;
        a_enq_rdy = 1'b0;
        next_cycle();
        reset = 1'b0;
    endtask

    function automatic logic [3:0] onehot(input int idx);
        logic [3:0] one;
        one = 4'b0001;
        return one << idx;
    endfunction

    // Behavioural reference for instance A
    int m_locked, m_owner, m_run, m_start, m_held, m_count;

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_run = 0; m_start = 0; m_held = -1; m_count = 0;
    endtask

    task automatic model_step(input int mb);
        int  sel;
        bit  v;
        bit  xfer;
        sel = -1;
        v   = 1'b0;
        if (m_locked != 0) begin
            sel = m_owner;
            v   = a_req_val[m_owner];
        end else if (m_held >= 0 && a_req_val[m_held]) begin
            sel = m_held;
            v   = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                int k;
                k = (m_start + i) % 4;
                if (sel < 0 && a_req_val[k]) begin
                    sel = k;
                    v   = 1'b1;
                end
            end
        end

        chk("rand_enq_val", a_enq_val, v);
        chk("rand_xfer_count", a_xfer_count, m_count);
        if (v) begin
            chk("rand_enq_src", a_enq_src, sel);
            chk("rand_enq_data", a_enq_data, a_req_data[sel*8 +: 8]);
            chk("rand_req_rdy", a_req_rdy, a_enq_rdy ? onehot(sel) : 4'b0000);
        end else begin
            chk("rand_req_rdy_idle", a_req_rdy, 4'b0000);
            if (m_locked == 0) begin
                chk("rand_idle_data", a_enq_data, 8'h00);
                chk("rand_idle_src", a_enq_src, 2'd0);
            end
        end

        xfer = v && a_enq_rdy;
        if (m_locked == 0) begin
            if (xfer) begin
                m_count = (m_count + 1) % 65536;
                m_owner = sel;
                m_run   = 1;
                m_held  = -1;
                if (mb == 1) m_start = (sel + 1) % 4;
                else         m_locked = 1;
            end else if (v) begin
                m_held = sel;
            end else begin
                m_held = -1;
            end
        end else begin
            if (!a_req_val[m_owner]) begin
                m_locked = 0;
                m_start  = (m_owner + 1) % 4;
            end else if (xfer) begin
                m_count = (m_count + 1) % 65536;
                m_run++;
                if (m_run == mb) begin
                    m_locked = 0;
                    m_start  = (m_owner + 1) % 4;
                end
            end
        end
    endtask

    typedef struct {
        logic [3:0] val;
        logic       rdy;
        logic [1:0] src;
        logic [7:0] data;
    } rr_vec_t;

    initial begin
        rr_vec_t    rr_tab[10];
        int         b_cnt[4];
        int         occ;
        int         d;
        logic [7:0] exp_d;

        rr_tab[0] = '{4'hF, 1'b1, 2'd0, 8'h10};
        rr_tab[1] = '{4'hF, 1'b1, 2'd0, 8'h11};
        rr_tab[2] = '{4'hF, 1'b1, 2'd1, 8'h20};
        rr_tab[3] = '{4'hF, 1'b1, 2'd1, 8'h21};
        rr_tab[4] = '{4'hF, 1'b1, 2'd2, 8'h30};
        rr_tab[5] = '{4'hF, 1'b1, 2'd2, 8'h31};
        rr_tab[6] = '{4'hF, 1'b1, 2'd3, 8'h40};
        rr_tab[7] = '{4'hF, 1'b1, 2'd3, 8'h41};
        rr_tab[8] = '{4'hF, 1'b1, 2'd0, 8'h12};
        rr_tab[9] = '{4'hF, 1'b1, 2'd0, 8'h13};

        reset      = 1'b1;
        a_req_val  = '0; a_req_data = '0; a_enq_rdy = 1'b0;
        b_req_val  = '0; b_req_data = '0; b_enq_rdy = 1'b0;

        // Reset state outputs
        repeat (2) @(posedge clk);
        #1;
        chk("reset_enq_val", a_enq_val, 1'b0);
        chk("reset_req_rdy", a_req_rdy, 4'b0000);
        chk("reset_enq_data", a_enq_data, 8'h00);
        chk("reset_enq_src", a_enq_src, 2'd0);
        chk("reset_xfer_count", a_xfer_count, 16'd0);
        reset = 1'b0;

        // Round robin with MAXBURST 2 (table-driven)
        for (int i = 0; i < 4; i++) b_cnt[i] = 0;
        for (int r = 0; r < 10; r++) begin
            b_req_val = rr_tab[r].val;
            b_enq_rdy = rr_tab[r].rdy;
            for (int i = 0; i < 4; i++) b_req_data[i*8 +: 8] = 8'((i + 1) * 16 + b_cnt[i]);
            #2;
            chk("rr_enq_val", b_enq_val, 1'b1);
            chk("rr_enq_src", b_enq_src, rr_tab[r].src);
            chk("rr_enq_data", b_enq_data, rr_tab[r].data);
            chk("rr_req_rdy", b_req_rdy, onehot(int'(rr_tab[r].src)));
            next_cycle();
            b_cnt[rr_tab[r].src]++;
        end
        chk("rr_xfer_count", b_xfer_count, 16'd10);
        b_req_val = '0;
        b_enq_rdy = 1'b0;

        // Single requester, eight back-to-back transfers across two bursts
        do_reset();
        a_enq_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_req_val        = 4'b0001;
            a_req_data[7:0]  = 8'(8'hA0 + i);
            #2;
            chk("single_enq_val", a_enq_val, 1'b1);
            chk("single_enq_src", a_enq_src, 2'd0);
            chk("single_enq_data", a_enq_data, 8'(8'hA0 + i));
            chk("single_req_rdy", a_req_rdy, 4'b0001);
            next_cycle();
        end
        chk("single_xfer_count", a_xfer_count, 16'd8);

        // Backpressure: 8-deep FIFO already holding 2 entries, requester 2 locked when it fills
        do_reset();
        occ = 2;
        d   = 0;
        a_req_val = 4'b0100;
        while (occ < 8) begin
            a_enq_rdy = 1'b1;
            a_req_data[23:16] = 8'(8'hC0 + d);
            #2;
            chk("bp_fill_src", a_enq_src, 2'd2);
            chk("bp_fill_rdy", a_req_rdy, 4'b0100);
            next_cycle();
            occ++;
            d++;
        end
        exp_d = 8'(8'hC0 + d);
        a_req_data[23:16] = exp_d;
        a_enq_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("bp_hold_val", a_enq_val, 1'b1);
            chk("bp_hold_src", a_enq_src, 2'd2);
            chk("bp_hold_data", a_enq_data, exp_d);
            chk("bp_hold_rdy", a_req_rdy, 4'b0000);
            next_cycle();
        end
        a_enq_rdy = 1'b1;
        #2;
        chk("bp_deq_rdy", a_req_rdy, 4'b0100);
        next_cycle();
        d++;
        a_req_data[23:16] = 8'(8'hC0 + d);
        a_enq_rdy = 1'b0;
        #2;
        chk("bp_after_rdy", a_req_rdy, 4'b0000);
        chk("bp_after_val", a_enq_val, 1'b1);
        chk("bp_after_data", a_enq_data, 8'(8'hC0 + d));
        chk("bp_xfer_count", a_xfer_count, 16'd7);
        next_cycle();

        // Owner drop: bubble, then rr_ptr=2 prefers requester 3 over 0
        do_reset();
        a_enq_rdy = 1'b1;
        a_req_val = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("drop_lock_src", a_enq_src, 2'd1);
            chk("drop_lock_rdy", a_req_rdy, 4'b0010);
            next_cycle();
        end
        a_req_val = 4'b1001;
        #2;
        chk("drop_bubble_val", a_enq_val, 1'b0);
        chk("drop_bubble_rdy", a_req_rdy, 4'b0000);
        next_cycle();
        #2;
        chk("drop_regrant_val", a_enq_val, 1'b1);
        chk("drop_regrant_src", a_enq_src, 2'd3);
        chk("drop_regrant_rdy", a_req_rdy, 4'b1000);
        next_cycle();

        // Reset mid-burst
        do_reset();
        a_enq_rdy = 1'b1;
        a_req_val = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("rst_burst_src", a_enq_src, 2'd0);
            next_cycle();
        end
        reset = 1'b1;
        #2;
        chk("rst_mid_req_rdy", a_req_rdy, 4'b0000);
        chk("rst_mid_enq_val", a_enq_val, 1'b0);
        next_cycle();
        reset = 1'b0;
        chk("rst_mid_xfer_count", a_xfer_count, 16'd0);
        a_req_val = 4'b0110;
        #2;
        chk("rst_next_src", a_enq_src, 2'd1);
        chk("rst_next_rdy", a_req_rdy, 4'b0010);
        next_cycle();

        // Randomized traffic against the behavioural model
        do_reset();
        model_reset();
        a_req_val = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) a_req_val[i] = ~a_req_val[i];
            end
            a_req_data = $urandom;
            a_enq_rdy  = ($urandom_range(0, 3) != 0);
            #2;
            model_step(4);
            next_cycle();
        end

        // Counter wrap
        do_reset();
        a_req_val  = 4'b0001;
        a_req_data = '0;
        a_enq_rdy  = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        chk("wrap_ffff", a_xfer_count, 16'hFFFF);
        next_cycle();
        chk("wrap_zero", a_xfer_count, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
